// File: rtl/systolic_is_sequencer.sv
// Sequencer feeding an input-stationary systolic array.
// Optional stall counter enabled by defining SEQ_PERF_CNT_EN.
module systolic_is_sequencer #(
    parameter int INPUT_WIDTH  = 16,
    parameter int WEIGHT_WIDTH = 16,
    parameter int PSUM_WIDTH   = 16,
    parameter int ARRAY_HEIGHT = 4,
    parameter int ARRAY_WIDTH  = 4,
    parameter int PIPE_LAT     = ARRAY_WIDTH + ARRAY_HEIGHT,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [CNT_WIDTH-1:0]               num_wvec,
    output logic                               busy,
    output logic                               done,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [INPUT_WIDTH*ARRAY_HEIGHT-1:0] in_data,
    input  logic                               w_valid,
    output logic                               w_ready,
    input  logic [WEIGHT_WIDTH*ARRAY_WIDTH-1:0] w_data,
    output logic                               input_en,
    output logic                               process_en,
    output logic [INPUT_WIDTH*ARRAY_HEIGHT-1:0] packed_input_in,
    output logic [WEIGHT_WIDTH*ARRAY_WIDTH-1:0] packed_weight_in,
    input  logic [PSUM_WIDTH*ARRAY_HEIGHT-1:0]  packed_psum_out,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [PSUM_WIDTH*ARRAY_HEIGHT-1:0]  out_data,
    output logic [31:0]                        stall_cycles
);

    localparam int LDW = $clog2(ARRAY_WIDTH + 1);
    localparam int DRW = $clog2(PIPE_LAT + 1);

    typedef enum logic [2:0] {
        IDLE, LOAD, STREAM, DRAIN, DONE
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [CNT_WIDTH-1:0]  wrem;
    logic [LDW-1:0]        ldcnt;
    logic [DRW-1:0]        drcnt;
    logic [PIPE_LAT-1:0]   tags;
    logic                  tag_in;
    logic                  adv;

    assign out_valid = tags[PIPE_LAT-1];
    assign adv       = !out_valid || out_ready;
    assign out_data  = packed_psum_out;

    // Next-state and all array/handshake controls
    always_comb begin
        state_nxt        = state;
        busy             = (state != IDLE);
        done             = 1'b0;
        in_ready         = 1'b0;
        w_ready          = 1'b0;
        input_en         = 1'b0;
        process_en       = 1'b0;
        packed_input_in  = '0;
        packed_weight_in = '0;
        tag_in           = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = LOAD;
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    input_en        = 1'b1;
                    packed_input_in = in_data;
                    if (ldcnt == LDW'(ARRAY_WIDTH - 1))
                        state_nxt = (wrem != '0) ? STREAM : DONE;
                end
            end
            STREAM: begin
                w_ready = adv;
                if (w_valid && adv) begin
                    process_en       = 1'b1;
                    packed_weight_in = w_data;
                    tag_in           = 1'b1;
                    if (wrem == CNT_WIDTH'(1)) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (adv) begin
                    process_en = 1'b1;
                    if (drcnt == DRW'(1)) state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Job counters: remaining weights, load beats, drain cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            wrem  <= '0;
            ldcnt <= '0;
            drcnt <= '0;
        end else begin
            if (state == IDLE && start) begin
                wrem  <= num_wvec;
                ldcnt <= '0;
            end
            if (input_en) ldcnt <= ldcnt + LDW'(1);
            if (state == STREAM && process_en) begin
                wrem <= wrem - CNT_WIDTH'(1);
                if (wrem == CNT_WIDTH'(1)) drcnt <= DRW'(PIPE_LAT);
            end
            if (state == DRAIN && process_en) drcnt <= drcnt - DRW'(1);
        end
    end

    // Row-valid tags travel alongside the array pipeline
    always_ff @(posedge clk) begin
        if (rst)             tags <= '0;
        else if (process_en) tags <= (tags << 1) | PIPE_LAT'(tag_in);
    end

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] stall_q;

    // Saturating count of frozen cycles while the array is active
    always_ff @(posedge clk) begin
        if (rst)
            stall_q <= '0;
        else if (state == IDLE && start)
            stall_q <= '0;
        else if ((state == STREAM || state == DRAIN) && !process_en
                 && stall_q != 32'hFFFF_FFFF)
            stall_q <= stall_q + 32'd1;
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_systolic_is_sequencer.sv
// Randomized bench for systolic_is_sequencer with a matmul scoreboard.
// Includes a behavioural array model standing in for the systolic array.
module tb_systolic_is_sequencer;

    localparam int AH = 4;
    localparam int AW = 4;
    localparam int PL = 8;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] num_wvec;
    logic        busy;
    logic        done;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        w_valid;
    logic        w_ready;
    logic [63:0] w_data;
    logic        input_en;
    logic        process_en;
    logic [63:0] packed_input_in;
    logic [63:0] packed_weight_in;
    logic [63:0] packed_psum_out;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [31:0] stall_cycles;

    int n_chk;
    int n_fail;

    systolic_is_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .num_wvec         (num_wvec),
        .busy             (busy),
        .done             (done),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_data          (in_data),
        .w_valid          (w_valid),
        .w_ready          (w_ready),
        .w_data           (w_data),
        .input_en         (input_en),
        .process_en       (process_en),
        .packed_input_in  (packed_input_in),
        .packed_weight_in (packed_weight_in),
        .packed_psum_out  (packed_psum_out),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .stall_cycles     (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Behavioural array: stationary matrix plus a PL-deep result pipe
    logic [15:0] stat [AH][AW];
    logic [63:0] apipe [PL];
    int          a_ld;
    bit          cap_rst, cap_start, cap_ie, cap_pe;
    logic [63:0] cap_pii, cap_pwi;

    function automatic logic [63:0] arr_row(input logic [63:0] w);
        logic [63:0] row;
        logic [15:0] acc;
        row = '0;
        for (int r = 0; r < AH; r++) begin
            acc = '0;
            for (int c = 0; c < AW; c++)
                acc = acc + stat[r][c] * w[16*c +: 16];
            row[16*r +: 16] = acc;
        end
        return row;
    endfunction

    always @(negedge clk) begin
        cap_rst   = rst;
        cap_start = start && !busy;
        cap_ie    = input_en;
        cap_pe    = process_en;
        cap_pii   = packed_input_in;
        cap_pwi   = packed_weight_in;
    end

    always @(posedge clk) begin
        if (cap_rst) begin
            a_ld = 0;
            for (int i = 0; i < PL; i++) apipe[i] = '0;
        end else begin
            if (cap_start) a_ld = 0;
            if (cap_ie && a_ld < AW) begin
                for (int r = 0; r < AH; r++)
                    stat[r][a_ld] = cap_pii[16*r +: 16];
                a_ld++;
            end
            if (cap_pe) begin
                for (int i = PL - 1; i > 0; i--) apipe[i] = apipe[i-1];
                apipe[0] = arr_row(cap_pwi);
            end
        end
    end

    assign packed_psum_out = apipe[PL-1];

    task automatic check_reset();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_w_ready", w_ready, 0);
        check("rst_input_en", input_en, 0);
        check("rst_process_en", process_en, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_stall", stall_cycles, 0);
        check("rst_pii", packed_input_in, 0);
        check("rst_pwi", packed_weight_in, 0);
        check("rst_out_data", out_data, apipe[PL-1]);
    endtask

    // One job: p_w < 0 means weight beats offered every other cycle
    task automatic run_job(input int nw, input int p_in, input int p_w,
                           input int p_or, input bit ident, input int hold,
                           input bit poke, input int abort_at);
        logic [15:0] im [AH][AW];
        logic [63:0] wq [$];
        logic [63:0] eq [$];
        logic [63:0] w, row, hold_data;
        logic [15:0] acc;
        int  li, wi, ri, cyc, sd_cnt, hold_left, exp_stall;
        bit  sd, pe_seen, held, poked, fin, chk_time;
        li = 0; wi = 0; ri = 0; sd_cnt = 0; hold_left = 0;
        sd = 0; pe_seen = 0; held = 0; poked = 0; fin = 0;
        hold_data = '0;
        chk_time = (p_in == 100 && p_w == 100 && p_or == 100 && hold == 0);
        for (int r = 0; r < AH; r++)
            for (int c = 0; c < AW; c++)
                im[r][c] = ident ? 16'(r == c) : 16'($urandom_range(0, 255));
        for (int k = 0; k < nw; k++) begin
            w = {$urandom, $urandom};
            wq.push_back(w);
            row = '0;
            for (int r = 0; r < AH; r++) begin
                acc = '0;
                for (int c = 0; c < AW; c++)
                    acc = acc + im[r][c] * w[16*c +: 16];
                row[16*r +: 16] = acc;
            end
            eq.push_back(row);
        end
        @(posedge clk); #1;
        start = 1'b1; num_wvec = 16'(nw);
        in_valid = 0; w_valid = 0; out_ready = 1;
        @(posedge clk); #1;
        start = 1'b0; num_wvec = 16'($urandom);
        for (cyc = 1; cyc <= 3000 && !fin; cyc++) begin
            if (abort_at > 0 && wi >= abort_at) begin
                rst = 1; in_valid = 0; w_valid = 0; out_ready = 1;
                @(posedge clk);
                @(negedge clk);
                check_reset();
                @(posedge clk); #1;
                rst = 0;
                return;
            end
            in_valid = (li < AW) && ($urandom_range(0, 99) < p_in);
            in_data  = {$urandom, $urandom};
            if (in_valid)
                for (int r = 0; r < AH; r++) in_data[16*r +: 16] = im[r][li];
            if (p_w < 0) w_valid = (wi < nw) && cyc[0];
            else         w_valid = (wi < nw) && ($urandom_range(0, 99) < p_w);
            w_data = w_valid ? wq[wi] : {$urandom, $urandom};
            if (hold > 0 && !held && out_valid) begin
                held = 1; hold_left = hold; hold_data = out_data;
            end
            out_ready = (hold_left > 0) ? 1'b0 : ($urandom_range(0, 99) < p_or);
            start = poke && !poked && wi == 1;
            if (start) begin
                poked = 1; num_wvec = 16'd7;
            end
            @(negedge clk);
            if (cyc == 1) check("busy", busy, 1);
            if (out_valid && !out_ready) check("stall_pe", process_en, 0);
            if (hold_left > 0) begin
                check("hold_data", out_data, hold_data);
                hold_left--;
            end
            if (!input_en) check("pii_zero", packed_input_in, 0);
            if (!(w_valid && w_ready)) check("pwi_zero", packed_weight_in, 0);
            if (process_en) pe_seen = 1;
            if (done) begin
                fin = 1;
                if (chk_time)
                    check("done_cyc", cyc, (nw > 0) ? AW + nw + PL + 1 : AW + 1);
                check("rows", ri, nw);
                check("wbeats", wi, nw);
                check("ldbeats", li, AW);
                check("pe_seen", pe_seen, nw > 0);
`ifdef SEQ_PERF_CNT_EN
                exp_stall = sd_cnt;
`else
                exp_stall = 0;
`endif
                check("stall_cnt", stall_cycles, exp_stall);
            end else begin
                if (sd && !process_en) sd_cnt++;
                if (out_valid && out_ready) begin
                    if (ri < nw) check("row", out_data, eq[ri]);
                    else         check("extra_row", ri, nw);
                    ri++;
                end
                if (w_valid && w_ready) wi++;
                if (in_valid && in_ready) begin
                    li++;
                    if (li == AW && nw > 0) sd = 1;
                end
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        in_valid = 0; w_valid = 0; out_ready = 1;
        if (!fin) check("timeout", 0, 1);
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        rst = 1; start = 0; num_wvec = '0;
        in_valid = 0; in_data = '0; w_valid = 0; w_data = '0; out_ready = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset();
        @(posedge clk); #1;
        rst = 0;
        run_job(3, 100, 100, 100, 1, 0, 0, 0);
        run_job(0, 100, 100, 100, 0, 0, 0, 0);
        run_job(3, 100, 100, 100, 1, 5, 0, 0);
        run_job(6, 100, -1, 100, 0, 0, 0, 0);
        run_job(5, 100, 100, 100, 0, 0, 0, 2);
        run_job(4, 100, 100, 100, 0, 0, 1, 0);
        for (int j = 0; j < 10; j++)
            run_job($urandom_range(1, 9), $urandom_range(30, 100),
                    $urandom_range(30, 100), $urandom_range(30, 100),
                    0, 0, 0, 0);
        run_job(5, 60, 60, 40, 0, 3, 1, 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
